// File: rtl/invsqrt_stream_ctrl_if.sv
// Stream and core-side signal bundle for invsqrt_stream_ctrl.
// slave: the controller's view. master: the environment's view (operand source, result sink, core).
interface invsqrt_stream_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_err;
  logic        core_start;
  logic [31:0] core_float_in;
  logic [31:0] core_float_out;
  logic        core_ready;

  modport slave (
    input  s_valid, s_data, m_ready, core_float_out, core_ready,
    output s_ready, m_valid, m_data, m_err, core_start, core_float_in
  );

  modport master (
    output s_valid, s_data, m_ready, core_float_out, core_ready,
    input  s_ready, m_valid, m_data, m_err, core_start, core_float_in
  );
endinterface

// File: rtl/invsqrt_stream_ctrl.sv
// Feeds buffered float operands to the invsqrt core one at a time and returns
// results in order. A hung core is abandoned after TIMEOUT cycles; in that case
// the result is a quiet NaN with m_err set.
module invsqrt_stream_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  invsqrt_stream_ctrl_if.slave        bus,
  output logic                        busy,
  output logic [7:0]                  timeout_cnt
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned TW       = $clog2(TIMEOUT);
  localparam int unsigned TMAX_I   = TIMEOUT - 1;
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [TW-1:0] TMAX     = TMAX_I[TW-1:0];
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_DRAIN} state_t;

  // Operand FIFO
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop, s_ready;

  // Control
  state_t        state_q;
  logic          ready_q;
  logic [TW-1:0] timer_q;
  logic          m_valid_q, m_err_q, core_start_q;
  logic [31:0]   m_data_q, core_in_q;
  logic [7:0]    tcnt_q;
  logic          capture;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign s_ready = !full && !rst;
  assign push    = bus.s_valid && s_ready;
  // A launch needs the output slot free and the core's done level low, so a
  // stale done from the previous transaction can never be taken as a result.
  assign pop     = (state_q == ST_IDLE) && !empty && !m_valid_q && !bus.core_ready;
  assign capture = bus.core_ready && !ready_q;

  assign bus.s_ready       = s_ready;
  assign bus.m_valid       = m_valid_q;
  assign bus.m_data        = m_data_q;
  assign bus.m_err         = m_err_q;
  assign bus.core_start    = core_start_q;
  assign bus.core_float_in = core_in_q;
  assign busy              = (state_q != ST_IDLE) || !empty;
  assign timeout_cnt       = tcnt_q;

  // Occupancy next value; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointers; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.s_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Transaction FSM with registered start pulse, operand and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      timer_q      <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_err_q      <= 1'b0;
      core_start_q <= 1'b0;
      core_in_q    <= '0;
      tcnt_q       <= '0;
    end else begin
      ready_q      <= bus.core_ready;
      core_start_q <= 1'b0;
      if (m_valid_q && bus.m_ready) m_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            core_in_q    <= mem_q[rd_ptr_q];
            core_start_q <= 1'b1;
            state_q      <= ST_START;
          end
        end
        ST_START: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          timer_q <= timer_q + 1'b1;
          // m_valid is known to be 0 here, so setting it cannot collide with the clear above.
          if (capture) begin
            m_data_q  <= bus.core_float_out;
            m_err_q   <= 1'b0;
            m_valid_q <= 1'b1;
            state_q   <= ST_DRAIN;
          end else if (timer_q == TMAX) begin
            m_data_q  <= QNAN;
            m_err_q   <= 1'b1;
            m_valid_q <= 1'b1;
            if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
            state_q   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!bus.core_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_invsqrt_stream_ctrl.sv
// Self-checking bench for invsqrt_stream_ctrl with a behavioural invsqrt core model.
module tb_invsqrt_stream_ctrl;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [7:0] timeout_cnt;

  invsqrt_stream_ctrl_if bif ();

  invsqrt_stream_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif),
    .busy        (busy),
    .timeout_cnt (timeout_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Core model controls
  bit          core_hang = 1'b0;
  bit          core_rand = 1'b0;
  int unsigned core_lat  = 4;
  int unsigned core_hold = 1;
  bit          bp_rand   = 1'b0;

  // Observation
  logic [31:0] acc_q[$];
  logic [31:0] obs_d[$];
  logic        obs_e[$];
  int          start_cnt = 0;
  bit          start_pre_ok = 1'b0;
  bit          saw_full = 1'b0;
  logic        prv_cr = 1'b0, prv_mv = 1'b0;

  // Reference invsqrt: exact 1/sqrt(k) bit patterns for small integers, an arbitrary bijection otherwise.
  function automatic logic [31:0] core_fn(input logic [31:0] x);
    case (x)
      32'h3F800000: return 32'h3F800000;
      32'h40000000: return 32'h3F3504F3;
      32'h40400000: return 32'h3F13CD3A;
      32'h40800000: return 32'h3F000000;
      32'h40A00000: return 32'h3EE4F92E;
      32'h40C00000: return 32'h3ED105EC;
      default:      return {x[15:0], ~x[31:16]};
    endcase
  endfunction

  // Monitor: everything sampled at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && bif.s_valid && bif.s_ready) acc_q.push_back(bif.s_data);
    if (bif.s_valid && !bif.s_ready) saw_full = 1'b1;
    if (bif.m_valid && bif.m_ready) begin
      obs_d.push_back(bif.m_data);
      obs_e.push_back(bif.m_err);
    end
    if (bif.core_start) begin
      start_cnt++;
      start_pre_ok = !prv_cr && !prv_mv;
    end
    prv_cr = bif.core_ready;
    prv_mv = bif.m_valid;
  end

  // Core model: done level rises lat cycles after start, held for hold cycles.
  initial begin : core_model
    logic [31:0] op;
    int unsigned lat, hold;
    bif.core_ready     = 1'b0;
    bif.core_float_out = '0;
    forever begin
      @(negedge clk);
      if (bif.core_start && !core_hang) begin
        op   = bif.core_float_in;
        lat  = core_rand ? $urandom_range(2, 8) : core_lat;
        hold = core_rand ? $urandom_range(1, 3) : core_hold;
        repeat (lat) @(posedge clk);
        #1;
        bif.core_float_out = core_fn(op);
        bif.core_ready     = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bif.core_ready = 1'b0;
      end
    end
  end

  // Random result backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_rand) bif.m_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  task automatic clear_obs();
    acc_q.delete();
    obs_d.delete();
    obs_e.delete();
    saw_full = 1'b0;
  endtask

  task automatic do_reset();
    bif.s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
  endtask

  // Offer one operand until accepted; called and returns at posedge+1.
  task automatic send(input logic [31:0] d, output bit ok);
    int n = 0;
    ok = 1'b0;
    bif.s_valid = 1'b1;
    bif.s_data  = d;
    do begin
      @(negedge clk);
      ok = bif.s_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 2000);
    bif.s_valid = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || bif.m_valid || bif.core_ready) && n < 3000);
    ok = (n < 3000);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bif.s_valid = 1'b0;
    bif.s_data  = '0;
    bif.m_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bif.s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b expected 0", bif.s_ready); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bif.m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b expected 0", bif.m_valid); else passes++;
    checks++; if (bif.m_data !== 32'h0) $display("FAIL rst_m_data: got %h expected 0", bif.m_data); else passes++;
    checks++; if (bif.m_err !== 1'b0) $display("FAIL rst_m_err: got %b expected 0", bif.m_err); else passes++;
    checks++; if (bif.core_start !== 1'b0) $display("FAIL rst_core_start: got %b expected 0", bif.core_start); else passes++;
    checks++; if (bif.core_float_in !== 32'h0) $display("FAIL rst_core_in: got %h expected 0", bif.core_float_in); else passes++;
    checks++; if (timeout_cnt !== 8'h0) $display("FAIL rst_tcnt: got %0d expected 0", timeout_cnt); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passes++;
    checks++; if (bif.s_ready !== 1'b1) $display("FAIL rst_s_ready_after: got %b expected 1", bif.s_ready); else passes++;
    @(posedge clk); #1;
    clear_obs();
  endtask

  task automatic test_single();
    int n;
    bit ok;
    core_hang = 1'b0; core_rand = 1'b0; core_lat = 10; core_hold = 2;
    bif.m_ready = 1'b1;
    clear_obs();
    bif.s_valid = 1'b1;
    bif.s_data  = 32'h40800000;
    @(negedge clk);
    checks++; if (bif.s_ready !== 1'b1) $display("FAIL single_accept: got %b expected 1", bif.s_ready); else passes++;
    @(posedge clk); #1;
    bif.s_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bif.core_start && n < 40);
    checks++; if (n != 2) $display("FAIL single_start_lat: got %0d expected 2", n); else passes++;
    checks++; if (bif.core_float_in !== 32'h40800000) $display("FAIL single_core_in: got %h expected 40800000", bif.core_float_in); else passes++;
    @(negedge clk);
    checks++; if (bif.core_start !== 1'b0) $display("FAIL single_start_width: got %b expected 0", bif.core_start); else passes++;
    n = 1;
    while (!bif.m_valid && n < 60) begin @(negedge clk); n++; end
    checks++; if (n != 11) $display("FAIL single_result_lat: got %0d expected 11", n); else passes++;
    checks++; if (bif.m_data !== 32'h3F000000) $display("FAIL single_m_data: got %h expected 3f000000", bif.m_data); else passes++;
    checks++; if (bif.m_err !== 1'b0) $display("FAIL single_m_err: got %b expected 0", bif.m_err); else passes++;
    checks++; if (bif.core_float_in !== 32'h40800000) $display("FAIL single_core_in_hold: got %h expected 40800000", bif.core_float_in); else passes++;
    @(posedge clk); #1;
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL single_drain: got timeout expected idle"); else passes++;
    checks++; if (obs_d.size() != 1) $display("FAIL single_beats: got %0d expected 1", obs_d.size()); else passes++;
  endtask

  task automatic test_burst();
    logic [31:0] ops [6] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] exp [6] = '{32'h3F800000, 32'h3F3504F3, 32'h3F13CD3A, 32'h3F000000, 32'h3EE4F92E, 32'h3ED105EC};
    bit ok;
    core_hang = 1'b0; core_rand = 1'b0; core_lat = 3; core_hold = 1;
    bif.m_ready = 1'b1;
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      send(ops[i], ok);
      checks++; if (!ok) $display("FAIL burst_send%0d: got stall expected accept", i); else passes++;
    end
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL burst_drain: got timeout expected idle"); else passes++;
    checks++; if (saw_full !== 1'b1) $display("FAIL burst_full: got %b expected 1", saw_full); else passes++;
    checks++; if (acc_q.size() != 6 || obs_d.size() != 6)
      $display("FAIL burst_count: got acc=%0d out=%0d expected 6/6", acc_q.size(), obs_d.size()); else passes++;
    for (int i = 0; i < 6 && i < obs_d.size(); i++) begin
      checks++; if (obs_d[i] !== exp[i] || obs_e[i] !== 1'b0)
        $display("FAIL burst_out%0d: got %h err=%b expected %h err=0", i, obs_d[i], obs_e[i], exp[i]); else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int n, bad, sc0;
    bit ok;
    core_hang = 1'b0; core_rand = 1'b0; core_lat = 3; core_hold = 1;
    bif.m_ready = 1'b0;
    clear_obs();
    for (int i = 0; i < 3; i++) send($urandom, ok);
    n = 0;
    do begin @(negedge clk); n++; end while (!bif.m_valid && n < 100);
    held = bif.m_data;
    checks++; if (held !== core_fn(acc_q[0])) $display("FAIL bp_first: got %h expected %h", held, core_fn(acc_q[0])); else passes++;
    sc0 = start_cnt;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bif.m_valid !== 1'b1 || bif.m_data !== held || bif.core_start !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); else passes++;
    checks++; if (start_cnt != sc0) $display("FAIL bp_no_launch: got %0d starts expected %0d", start_cnt, sc0); else passes++;
    @(posedge clk); #1;
    bif.m_ready = 1'b1;
    @(posedge clk); #1;
    bif.m_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bif.core_start && n < 10);
    checks++; if (!bif.core_start || n > 2) $display("FAIL bp_relaunch: got %0d cycles expected <=2", n); else passes++;
    @(posedge clk); #1;
    bif.m_ready = 1'b1;
    wait_drain(ok);
    checks++; if (!ok || obs_d.size() != 3) $display("FAIL bp_count: got %0d beats expected 3", obs_d.size()); else passes++;
    for (int i = 0; i < 3 && i < obs_d.size(); i++) begin
      checks++; if (obs_d[i] !== core_fn(acc_q[i]) || obs_e[i] !== 1'b0)
        $display("FAIL bp_out%0d: got %h expected %h", i, obs_d[i], core_fn(acc_q[i])); else passes++;
    end
  endtask

  task automatic test_timeout();
    logic [31:0] op2;
    int n;
    bit ok;
    do_reset();
    core_hang = 1'b1; core_rand = 1'b0;
    bif.m_ready = 1'b1;
    send(32'h41000000, ok);
    n = 0;
    while (!bif.core_start && n < 20) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!bif.m_valid && n < 200);
    checks++; if (n != TO + 1) $display("FAIL to_latency: got %0d expected %0d", n, TO + 1); else passes++;
    checks++; if (bif.m_data !== 32'h7FC00000) $display("FAIL to_data: got %h expected 7fc00000", bif.m_data); else passes++;
    checks++; if (bif.m_err !== 1'b1) $display("FAIL to_err: got %b expected 1", bif.m_err); else passes++;
    checks++; if (timeout_cnt !== 8'd1) $display("FAIL to_cnt: got %0d expected 1", timeout_cnt); else passes++;
    @(posedge clk); #1;
    wait_drain(ok);
    core_hang = 1'b0; core_lat = 4; core_hold = 1;
    op2 = $urandom;
    send(op2, ok);
    wait_drain(ok);
    checks++; if (!ok || obs_d.size() != 2) $display("FAIL to_count: got %0d beats expected 2", obs_d.size()); else passes++;
    checks++; if (obs_d[$] !== core_fn(op2) || obs_e[$] !== 1'b0)
      $display("FAIL to_recover: got %h err=%b expected %h err=0", obs_d[$], obs_e[$], core_fn(op2)); else passes++;
    checks++; if (timeout_cnt !== 8'd1) $display("FAIL to_cnt_hold: got %0d expected 1", timeout_cnt); else passes++;
  endtask

  task automatic test_stale_ready();
    int sc0;
    bit ok;
    core_hang = 1'b0; core_rand = 1'b0; core_lat = 3; core_hold = 5;
    bif.m_ready = 1'b1;
    clear_obs();
    sc0 = start_cnt;
    send($urandom, ok);
    send($urandom, ok);
    wait_drain(ok);
    checks++; if (!ok || obs_d.size() != 2) $display("FAIL stale_beats: got %0d expected 2", obs_d.size()); else passes++;
    checks++; if (start_cnt - sc0 != 2) $display("FAIL stale_starts: got %0d expected 2", start_cnt - sc0); else passes++;
    checks++; if (start_pre_ok !== 1'b1) $display("FAIL stale_gate: got %b expected 1", start_pre_ok); else passes++;
    for (int i = 0; i < 2 && i < obs_d.size(); i++) begin
      checks++; if (obs_d[i] !== core_fn(acc_q[i]))
        $display("FAIL stale_out%0d: got %h expected %h", i, obs_d[i], core_fn(acc_q[i])); else passes++;
    end
  endtask

  task automatic test_reset_mid_wait();
    int n, bad, sc0, ob0;
    bit ok;
    core_hang = 1'b1; core_rand = 1'b0;
    bif.m_ready = 1'b1;
    clear_obs();
    for (int i = 0; i < 3; i++) send($urandom, ok);
    n = 0;
    while (!bif.core_start && n < 20) begin @(negedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bif.m_valid !== 1'b0 || bif.m_data !== 32'h0 || bif.m_err !== 1'b0)
      $display("FAIL rmw_outputs: got v=%b d=%h e=%b expected 0", bif.m_valid, bif.m_data, bif.m_err); else passes++;
    checks++; if (bif.core_start !== 1'b0 || bif.core_float_in !== 32'h0)
      $display("FAIL rmw_core: got s=%b in=%h expected 0", bif.core_start, bif.core_float_in); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rmw_busy: got %b expected 0", busy); else passes++;
    checks++; if (timeout_cnt !== 8'd0) $display("FAIL rmw_tcnt: got %0d expected 0", timeout_cnt); else passes++;
    sc0 = start_cnt;
    ob0 = obs_d.size();
    @(posedge clk); #1;
    @(posedge clk); #1;
    bif.core_float_out = $urandom;
    bif.core_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bif.core_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bif.m_valid || bif.core_start || busy) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rmw_late_ready: got %0d active cycles expected 0", bad); else passes++;
    checks++; if (start_cnt != sc0 || obs_d.size() != ob0)
      $display("FAIL rmw_no_result: got starts=%0d beats=%0d expected %0d/%0d", start_cnt, obs_d.size(), sc0, ob0); else passes++;
    @(posedge clk); #1;
    core_hang = 1'b0;
    clear_obs();
  endtask

  task automatic test_random();
    int bad;
    bit ok;
    do_reset();
    core_hang = 1'b0; core_rand = 1'b1;
    bp_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send($urandom, ok);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    bp_rand = 1'b0;
    bif.m_ready = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL rand_drain: got timeout expected idle"); else passes++;
    checks++; if (acc_q.size() != 30 || obs_d.size() != 30)
      $display("FAIL rand_count: got acc=%0d out=%0d expected 30/30", acc_q.size(), obs_d.size()); else passes++;
    bad = 0;
    for (int i = 0; i < 30 && i < obs_d.size() && i < acc_q.size(); i++)
      if (obs_d[i] !== core_fn(acc_q[i]) || obs_e[i] !== 1'b0) bad++;
    checks++; if (bad != 0) $display("FAIL rand_order: got %0d wrong results expected 0", bad); else passes++;
    checks++; if (timeout_cnt !== 8'd0) $display("FAIL rand_tcnt: got %0d expected 0", timeout_cnt); else passes++;
    core_rand = 1'b0;
  endtask

  initial begin
    bif.s_valid = 1'b0;
    bif.s_data  = '0;
    bif.m_ready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_timeout();
    test_stale_ready();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
